// File: rtl/dq_tx_seq_if.sv
// Handshake and pad-side bundle for the dq_tx_seq write-burst sequencer.
// The controller (master) drives burst requests and write words; the
// sequencer (slave) drives the registered pad-side outputs and wr_ready.
// Optional byte-mask output dm_out exists only when DQ_TX_SEQ_DM_EN is defined.
interface dq_tx_seq_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PRE_WIDTH  = 3
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  byte_cnt;
  logic [PRE_WIDTH-1:0]  pre_cycles;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] dq_out_16;
  logic                  dq_oe;
  logic                  dqs_en;
  logic                  busy;
  logic                  done;
  logic                  underrun;
`ifdef DQ_TX_SEQ_DM_EN
  logic [1:0]            dm_out;

  modport master (
    output start, byte_cnt, pre_cycles, wr_data, wr_valid,
    input  wr_ready, dq_out_16, dq_oe, dqs_en, busy, done, underrun, dm_out
  );

  modport slave (
    input  start, byte_cnt, pre_cycles, wr_data, wr_valid,
    output wr_ready, dq_out_16, dq_oe, dqs_en, busy, done, underrun, dm_out
  );
`else
  modport master (
    output start, byte_cnt, pre_cycles, wr_data, wr_valid,
    input  wr_ready, dq_out_16, dq_oe, dqs_en, busy, done, underrun
  );

  modport slave (
    input  start, byte_cnt, pre_cycles, wr_data, wr_valid,
    output wr_ready, dq_out_16, dq_oe, dqs_en, busy, done, underrun
  );
`endif
endinterface

// File: rtl/dq_tx_seq.sv
// Write-burst sequencer for the PHY transmit path.
// Accepts 16-bit words over valid/ready and presents them registered on
// dq_out_16 (low byte first) with dq_oe/dqs_en framing: programmable
// preamble, one-cycle postamble, odd-byte tail and sticky underrun flag.
// Optional feature macro: DQ_TX_SEQ_DM_EN adds the registered dm_out mask.
// Registered outputs lag the FSM state by one cycle: each state computes the
// pad values that appear during the following clock.
module dq_tx_seq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PRE_WIDTH  = 3
) (
  input logic        clk,
  input logic        reset_n,
  dq_tx_seq_if.slave bus
);

  localparam int unsigned HalfW = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPre  = 2'd1,
    StData = 2'd2,
    StPost = 2'd3
  } state_e;

  state_e                r_state, w_state_d;
  logic [CNT_WIDTH-1:0]  r_rem, w_rem_d;
  logic [PRE_WIDTH-1:0]  r_pre_cnt, w_pre_cnt_d;
  logic                  r_zero, w_zero_d;
  logic                  r_busy, w_busy_d;
  logic                  r_underrun, w_underrun_d;
  logic [DATA_WIDTH-1:0] r_dq, w_dq_d;
  logic                  r_dq_oe, w_dq_oe_d;
  logic                  r_dqs_en, w_dqs_en_d;
  logic                  r_done, w_done_d;
`ifdef DQ_TX_SEQ_DM_EN
  logic [1:0]            r_dm, w_dm_d;
`endif

  logic w_ready;
  logic w_hs;
  logic w_last;

  assign w_ready = (r_state == StData) && (r_rem != '0);
  assign w_hs    = w_ready && bus.wr_valid;
  assign w_last  = (r_rem <= CNT_WIDTH'(2));

  // Next-state, counter and registered-output computation
  always_comb begin
    w_state_d    = r_state;
    w_rem_d      = r_rem;
    w_pre_cnt_d  = r_pre_cnt;
    w_zero_d     = r_zero;
    w_busy_d     = r_busy;
    w_underrun_d = r_underrun;
    w_dq_d       = '0;
    w_dq_oe_d    = 1'b0;
    w_dqs_en_d   = 1'b0;
    w_done_d     = 1'b0;
`ifdef DQ_TX_SEQ_DM_EN
    w_dm_d       = 2'b11;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_rem_d      = bus.byte_cnt;
          w_pre_cnt_d  = bus.pre_cycles;
          w_zero_d     = (bus.byte_cnt == '0);
          w_underrun_d = 1'b0;
          w_busy_d     = 1'b1;
          if (bus.byte_cnt == '0) begin
            w_state_d = StPost;
          end else if (bus.pre_cycles == '0) begin
            w_state_d = StData;
          end else begin
            w_state_d = StPre;
          end
        end
      end
      StPre: begin
        w_dq_oe_d   = 1'b1;
        w_pre_cnt_d = (r_pre_cnt != '0) ? r_pre_cnt - PRE_WIDTH'(1) : '0;
        if (r_pre_cnt <= PRE_WIDTH'(1)) begin
          w_state_d = StData;
        end
      end
      StData: begin
        w_dq_oe_d = 1'b1;
        if (w_hs) begin
          w_dq_d     = bus.wr_data;
          w_dqs_en_d = 1'b1;
`ifdef DQ_TX_SEQ_DM_EN
          w_dm_d     = 2'b00;
`endif
          // Odd tail: only the low byte carries data
          if (r_rem == CNT_WIDTH'(1)) begin
            w_dq_d[DATA_WIDTH-1:HalfW] = '0;
`ifdef DQ_TX_SEQ_DM_EN
            w_dm_d = 2'b10;
`endif
          end
          w_rem_d = w_last ? '0 : r_rem - CNT_WIDTH'(2);
          if (w_last) begin
            w_state_d = StPost;
          end
        end else if (w_ready) begin
          // Data owed but none offered: stretch the burst, flag it
          w_underrun_d = 1'b1;
        end else begin
          w_state_d = StPost;
        end
      end
      StPost: begin
        w_dq_oe_d = ~r_zero;
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered outputs with async active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_rem      <= '0;
      r_pre_cnt  <= '0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_dq       <= '0;
      r_dq_oe    <= 1'b0;
      r_dqs_en   <= 1'b0;
      r_done     <= 1'b0;
`ifdef DQ_TX_SEQ_DM_EN
      r_dm       <= 2'b11;
`endif
    end else begin
      r_state    <= w_state_d;
      r_rem      <= w_rem_d;
      r_pre_cnt  <= w_pre_cnt_d;
      r_zero     <= w_zero_d;
      r_busy     <= w_busy_d;
      r_underrun <= w_underrun_d;
      r_dq       <= w_dq_d;
      r_dq_oe    <= w_dq_oe_d;
      r_dqs_en   <= w_dqs_en_d;
      r_done     <= w_done_d;
`ifdef DQ_TX_SEQ_DM_EN
      r_dm       <= w_dm_d;
`endif
    end
  end

  assign bus.wr_ready  = w_ready;
  assign bus.dq_out_16 = r_dq;
  assign bus.dq_oe     = r_dq_oe;
  assign bus.dqs_en    = r_dqs_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.underrun  = r_underrun;
`ifdef DQ_TX_SEQ_DM_EN
  assign bus.dm_out    = r_dm;
`endif

endmodule

// File: tb/tb_dq_tx_seq.sv
// Self-checking bench for dq_tx_seq: a timeline model builds expected
// per-cycle outputs for each burst from byte count, preamble and the chosen
// wr_valid pattern; one process compares every cycle; directed literals pin it.
module tb_dq_tx_seq;
  localparam int MaxC = 6000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dq_tx_seq_if bus_if ();
  dq_tx_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus_if));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus schedule and expected outputs, indexed by cycle
  bit          drv_start [MaxC];
  bit          drv_valid [MaxC];
  logic [15:0] drv_data  [MaxC];
  logic [15:0] drv_cnt   [MaxC];
  logic [2:0]  drv_pre   [MaxC];
  bit          e_ready [MaxC], e_oe [MaxC], e_dqs [MaxC];
  bit          e_busy  [MaxC], e_done [MaxC], e_under [MaxC];
  logic [15:0] e_dq [MaxC];
  logic [1:0]  e_dm [MaxC];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n_oe, n_dqs, n_done, n_hs, n_ready, n_idle, done_cyc;
  logic [15:0] dq_seen[$];
  logic [1:0]  dm_seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_oe = 0; n_dqs = 0; n_done = 0; n_hs = 0; n_ready = 0; n_idle = 0; done_cyc = -1;
    dq_seen.delete();
    dm_seen.delete();
  endtask

  task automatic set_idle_exp(input int from);
    for (int c = from; c < MaxC; c++) begin
      e_ready[c] = 0; e_oe[c] = 0; e_dqs[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_under[c] = 0; e_dq[c] = '0; e_dm[c] = 2'b11; drv_start[c] = 0;
    end
  endtask

  // Per-cycle compare against the model, mid-cycle away from the edge
  initial forever begin
    @(negedge clk);
    if (chk_en && cyc < MaxC) begin
      chk("wr_ready", bus_if.wr_ready, e_ready[cyc]);
      chk("dq_oe", bus_if.dq_oe, e_oe[cyc]);
      chk("dqs_en", bus_if.dqs_en, e_dqs[cyc]);
      chk("dq_out_16", bus_if.dq_out_16, e_dq[cyc]);
      chk("busy", bus_if.busy, e_busy[cyc]);
      chk("done", bus_if.done, e_done[cyc]);
      chk("underrun", bus_if.underrun, e_under[cyc]);
`ifdef DQ_TX_SEQ_DM_EN
      chk("dm_out", bus_if.dm_out, e_dm[cyc]);
`endif
      if (bus_if.dq_oe) n_oe++;
      if (bus_if.dqs_en) begin
        n_dqs++;
        dq_seen.push_back(bus_if.dq_out_16);
`ifdef DQ_TX_SEQ_DM_EN
        dm_seen.push_back(bus_if.dm_out);
`endif
      end
      if (bus_if.done) begin n_done++; done_cyc = cyc; end
      if (bus_if.wr_ready) n_ready++;
      if (bus_if.wr_ready && bus_if.wr_valid) n_hs++;
      if (bus_if.dq_oe && !bus_if.dqs_en && !bus_if.done) n_idle++;
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    bus_if.start      = drv_start[cyc];
    bus_if.byte_cnt   = drv_cnt[cyc];
    bus_if.pre_cycles = drv_pre[cyc];
    bus_if.wr_valid   = drv_valid[cyc];
    bus_if.wr_data    = drv_data[cyc];
  endtask

  // Build the burst timeline: start in cycle s, outputs lag actions by one
  task automatic sched(input int n, input int p, input int vpct, input bit directed,
                       input logic [15:0] w0, input logic [15:0] w1, input int stalls,
                       input bit restart, input int gap,
                       output int s, output int d0, output int e);
    int rem, k, nw, c;
    bit v;
    logic [15:0] w;
    s = cyc + 1 + gap;
    drv_start[s] = 1; drv_cnt[s] = 16'(n); drv_pre[s] = 3'(p);
    for (int j = s + 1; j < MaxC; j++) e_under[j] = 0;
    d0 = s + 1 + p;
    if (n == 0) begin
      e_busy[s+1] = 1; e_done[s+2] = 1; e = s + 2;
    end else begin
      for (int j = s + 1; j <= s + p; j++) begin e_busy[j] = 1; e_oe[j+1] = 1; end
      rem = n; k = 0; nw = 0;
      while (rem > 0) begin
        c = d0 + k;
        e_busy[c] = 1; e_ready[c] = 1; e_oe[c+1] = 1;
        if (directed) v = (k == 0) || (k > stalls);
        else v = ($urandom_range(99) < vpct) || (k > 100);
        drv_valid[c] = v;
        if (v) begin
          w = directed ? (nw == 0 ? w0 : (nw == 1 ? w1 : 16'($urandom))) : 16'($urandom);
          drv_data[c] = w; e_dqs[c+1] = 1;
          if (rem == 1) begin
            e_dq[c+1] = {8'h00, w[7:0]}; e_dm[c+1] = 2'b10; rem = 0;
          end else begin
            e_dq[c+1] = w; e_dm[c+1] = 2'b00; rem -= 2;
          end
          nw++;
        end else if (!e_under[c+1]) begin
          for (int j = c + 1; j < MaxC; j++) e_under[j] = 1;
        end
        k++;
      end
      e_busy[d0+k] = 1; e_oe[d0+k+1] = 1; e_done[d0+k+1] = 1; e = d0 + k + 1;
      if (restart) begin drv_start[d0] = 1; drv_cnt[d0] = 16'd8; drv_pre[d0] = 3'($urandom); end
    end
  endtask

  task automatic run_burst(input int n, input int p, input int vpct, input bit directed,
                           input logic [15:0] w0, input logic [15:0] w1, input int stalls,
                           input bit restart, input int gap, output int s);
    int d0, e;
    sched(n, p, vpct, directed, w0, w1, stalls, restart, gap, s, d0, e);
    while (cyc < e) drive_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int s, d0, e;
    for (int c = 0; c < MaxC; c++) begin
      drv_start[c] = 0; drv_valid[c] = 1'($urandom); drv_data[c] = 16'($urandom);
      drv_cnt[c] = 16'($urandom_range(20)); drv_pre[c] = 3'($urandom);
    end
    set_idle_exp(0);
    bus_if.start = 0; bus_if.byte_cnt = '0; bus_if.pre_cycles = '0;
    bus_if.wr_valid = 0; bus_if.wr_data = '0;
    reset_n = 1'b0;
    #1;
    chk("rst_dq_oe", bus_if.dq_oe, 0);
    chk("rst_dqs_en", bus_if.dqs_en, 0);
    chk("rst_dq", bus_if.dq_out_16, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_ready", bus_if.wr_ready, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_underrun", bus_if.underrun, 0);
`ifdef DQ_TX_SEQ_DM_EN
    chk("rst_dm", bus_if.dm_out, 2'b11);
`endif
    clr_mon();
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Basic 4-byte burst with 2 preamble cycles
    clr_mon();
    run_burst(4, 2, 100, 1, 16'hA1B2, 16'hC3D4, 0, 0, 0, s);
    chk("t1_oe_cycles", n_oe, 5);
    chk("t1_dqs_cycles", n_dqs, 2);
    chk("t1_word0", dq_seen.size() > 0 ? dq_seen[0] : 16'hxxxx, 16'hA1B2);
    chk("t1_word1", dq_seen.size() > 1 ? dq_seen[1] : 16'hxxxx, 16'hC3D4);
    chk("t1_done", n_done, 1);
    chk("t1_underrun", bus_if.underrun, 0);

    // Odd byte count, no preamble
    clr_mon();
    run_burst(3, 0, 100, 1, 16'h1122, 16'h3344, 0, 0, 1, s);
    chk("t2_handshakes", n_hs, 2);
    chk("t2_word0", dq_seen.size() > 0 ? dq_seen[0] : 16'hxxxx, 16'h1122);
    chk("t2_word1", dq_seen.size() > 1 ? dq_seen[1] : 16'hxxxx, 16'h0044);
`ifdef DQ_TX_SEQ_DM_EN
    chk("t2_dm0", dm_seen.size() > 0 ? dm_seen[0] : 2'bxx, 2'b00);
    chk("t2_dm1", dm_seen.size() > 1 ? dm_seen[1] : 2'bxx, 2'b10);
`endif

    // Three stalled data cycles after the first word
    clr_mon();
    run_burst(4, 0, 100, 1, 16'h5A5A, 16'hA5A5, 3, 0, 0, s);
    chk("t3_idle_data", n_idle, 3);
    chk("t3_underrun", bus_if.underrun, 1);
    chk("t3_handshakes", n_hs, 2);

    // Zero-byte burst; also clears the underrun left above
    clr_mon();
    run_burst(0, 5, 100, 1, 16'h0, 16'h0, 0, 0, 0, s);
    chk("t4_oe_cycles", n_oe, 0);
    chk("t4_ready_cycles", n_ready, 0);
    chk("t4_done_delay", done_cyc - s, 2);
    chk("t4_underrun", bus_if.underrun, 0);

    // Start pulsed mid-burst with byte_cnt=8 must be ignored
    clr_mon();
    run_burst(4, 1, 100, 1, 16'h0F0F, 16'hF0F0, 0, 1, 0, s);
    chk("t5_oe_cycles", n_oe, 4);
    chk("t5_handshakes", n_hs, 2);
    chk("t5_done", n_done, 1);

    // Async reset during DATA, then a clean 2-byte burst
    sched(8, 1, 100, 1, 16'h1357, 16'h2468, 0, 0, 0, s, d0, e);
    while (cyc < d0 + 1) drive_cycle();
    set_idle_exp(cyc);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_dq_oe", bus_if.dq_oe, 0);
    chk("mr_dqs_en", bus_if.dqs_en, 0);
    chk("mr_dq", bus_if.dq_out_16, 0);
    chk("mr_busy", bus_if.busy, 0);
    chk("mr_ready", bus_if.wr_ready, 0);
    drive_cycle();
    #2 reset_n = 1'b1;
    clr_mon();
    run_burst(2, 0, 100, 1, 16'hBEEF, 16'h0, 0, 0, 0, s);
    chk("t6_handshakes", n_hs, 1);
    chk("t6_word0", dq_seen.size() > 0 ? dq_seen[0] : 16'hxxxx, 16'hBEEF);
    chk("t6_done", n_done, 1);

    // Randomized bursts against the timeline model
    for (int i = 0; i < 40 && cyc < MaxC - 400; i++) begin
      int n, p;
      n = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(12, 1));
      p = int'($urandom_range(7));
      run_burst(n, p, int'($urandom_range(100, 40)), 0, 16'h0, 16'h0, 0,
                $urandom_range(3) == 0, int'($urandom_range(2)), s);
    end

    drive_cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(MaxC * 10 + 1000);
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end
endmodule
